// File: rtl/mem_access_unit.sv
// Load/store unit between a single-request CPU port and a word-wide data memory.
// Byte and halfword stores go through a read-modify-write of the target word.
module mem_access_unit #(
    parameter int unsigned MEM_WORDS = 21
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] read_address,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    output logic        mem_write
);

    localparam logic [1:0]  SIZE_BYTE = 2'b00;
    localparam logic [1:0]  SIZE_HALF = 2'b01;
    localparam logic [1:0]  SIZE_WORD = 2'b10;
    localparam logic [1:0]  SIZE_BAD  = 2'b11;
    localparam logic [31:0] WORDS_W   = 32'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_off;
    logic [15:0] r_wdata;

    logic        accept_c;
    logic        req_err_c;
    logic [7:0]  byte_lane_c;
    logic [15:0] half_lane_c;
    logic [31:0] load_c;
    logic [31:0] merge_c;

    // Request handshake and legality of the request currently presented
    always_comb begin
        accept_c  = req_valid && req_ready && (state == IDLE);
        req_err_c = 1'b0;
        if (req_size == SIZE_BAD)
            req_err_c = 1'b1;
        if ((req_size == SIZE_HALF) && req_addr[0])
            req_err_c = 1'b1;
        if ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
            req_err_c = 1'b1;
        if (32'(req_addr[31:2]) >= WORDS_W)
            req_err_c = 1'b1;
    end

    // Little-endian lane extraction and extension of the word being read
    always_comb begin
        byte_lane_c = read_data[{r_off, 3'b000} +: 8];
        half_lane_c = read_data[{r_off[1], 4'b0000} +: 16];
        load_c      = read_data;
        case (r_size)
            SIZE_BYTE: load_c = r_signed ? {{24{byte_lane_c[7]}}, byte_lane_c}
                                         : {24'b0, byte_lane_c};
            SIZE_HALF: load_c = r_signed ? {{16{half_lane_c[15]}}, half_lane_c}
                                         : {16'b0, half_lane_c};
            default:   load_c = read_data;
        endcase
    end

    // Sub-word store: replace only the addressed lane of the word read back
    always_comb begin
        merge_c = read_data;
        if (r_size == SIZE_BYTE)
            merge_c[{r_off, 3'b000} +: 8] = r_wdata[7:0];
        else
            merge_c[{r_off[1], 4'b0000} +: 16] = r_wdata;
    end

    // Control FSM with registered handshake, memory and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= 32'b0;
            read_address  <= 32'b0;
            write_address <= 32'b0;
            write_data    <= 32'b0;
            mem_write     <= 1'b0;
            r_write       <= 1'b0;
            r_size        <= 2'b00;
            r_signed      <= 1'b0;
            r_off         <= 2'b00;
            r_wdata       <= 16'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            mem_write  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        req_ready     <= 1'b0;
                        r_write       <= req_write;
                        r_size        <= req_size;
                        r_signed      <= req_signed;
                        r_off         <= req_addr[1:0];
                        r_wdata       <= req_wdata[15:0];
                        read_address  <= {2'b00, req_addr[31:2]};
                        write_address <= {2'b00, req_addr[31:2]};
                        if (req_err_c) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'b0;
                        end else if (req_write && (req_size == SIZE_WORD)) begin
                            state      <= WR;
                            mem_write  <= 1'b1;
                            write_data <= req_wdata;
                        end else begin
                            state <= RD;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                RD: begin
                    if (r_write) begin
                        state      <= WR;
                        mem_write  <= 1'b1;
                        write_data <= merge_c;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_c;
                    end
                end
                WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'b0;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, corner sequences, random ops.
module tb_mem_access_unit;

    localparam int unsigned MW = 21;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] read_address;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        mem_write;

    logic [31:0] mem [MW];
    logic [31:0] ref_mem [MW];
    logic        mem_clear;
    int          mw_count = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
        int          lat;
    } vec_t;

    vec_t tbl[17];

    mem_access_unit #(.MEM_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .read_address(read_address), .write_address(write_address),
        .write_data(write_data), .read_data(read_data), .mem_write(mem_write)
    );

    always #5 clk = ~clk;

    // Attached data memory: combinational read, write on posedge when strobed
    assign read_data = (read_address < 32'(MW)) ? mem[read_address[4:0]] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < int'(MW); i++) mem[i] <= 32'b0;
        end else if (mem_write && (write_address < 32'(MW))) begin
            mem[write_address[4:0]] <= write_data;
        end
        if (mem_write) mw_count <= mw_count + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Reference model: expected outcome of one request, updates ref_mem for stores
    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic e, output logic [31:0] rd, output int lat);
        int unsigned idx;
        int unsigned off;
        logic [31:0] word, lane, mask;
        idx = a >> 2;
        off = a & 32'd3;
        e = (sz == 2'd3) || (sz == 2'd1 && (off % 2) == 1) ||
            (sz == 2'd2 && off != 0) || (idx >= MW);
        rd = 32'b0;
        if (e) begin
            lat = 1;
        end else begin
            word = ref_mem[idx[4:0]];
            if (!w) begin
                lat = 2;
                lane = word >> (8 * off);
                if (sz == 2'd0) begin
                    lane = lane & 32'hFF;
                    if (sg && lane >= 32'h80) lane = lane | 32'hFFFFFF00;
                end else if (sz == 2'd1) begin
                    lane = lane & 32'hFFFF;
                    if (sg && lane >= 32'h8000) lane = lane | 32'hFFFF0000;
                end else begin
                    lane = word;
                end
                rd = lane;
            end else if (sz == 2'd2) begin
                lat = 2;
                ref_mem[idx[4:0]] = wd;
            end else begin
                lat = 3;
                mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << (8 * off);
                ref_mem[idx[4:0]] = (word & ~mask) | ((wd << (8 * off)) & mask);
            end
        end
    endtask

    // Issue one request and check latency, response, write pulses and memory contents
    task automatic do_req(input string nm, input logic w, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input logic e_err, input logic [31:0] e_rd, input int e_lat);
        int t;
        int lat;
        int mw0;
        logic [31:0] idx;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL %s_accept actual=timeout required=req_ready", nm);
            req_valid = 1'b0;
            return;
        end
        mw0 = mw_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        chk({nm, "_lat"}, 32'(lat), 32'(e_lat));
        chk({nm, "_err"}, 32'(resp_err), 32'(e_err));
        chk({nm, "_rdata"}, resp_rdata, e_rd);
        chk({nm, "_ready_in_resp"}, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_valid_pulse"}, 32'(resp_valid), 32'd0);
        chk({nm, "_mem_writes"}, 32'(mw_count - mw0), (w && !e_err) ? 32'd1 : 32'd0);
        idx = a >> 2;
        if (idx < 32'(MW)) chk({nm, "_mem"}, mem[idx[4:0]], ref_mem[idx[4:0]]);
    endtask

    initial begin
        logic        e;
        logic [31:0] rd;
        int          lat;
        int          mw0;
        logic [31:0] a;
        logic        w, sg;
        logic [1:0]  sz;
        logic [31:0] wd;
        bit [4:0]    exp_r;
        bit [4:0]    exp_v;
        int          t;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 1'b0, 32'h0,        2};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h08, 32'h0,        1'b0, 32'hDEADBEEF, 2};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h04, 32'h11223344, 1'b0, 32'h0,        2};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h06, 32'h000000AA, 1'b0, 32'h0,        3};
        tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h04, 32'h0,        1'b0, 32'h11AA3344, 2};
        tbl[5]  = '{1'b1, 2'd2, 1'b0, 32'h00, 32'h0000F080, 1'b0, 32'h0,        2};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 32'h00, 32'h0,        1'b0, 32'hFFFFFF80, 2};
        tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h00, 32'h0,        1'b0, 32'h0000F080, 2};
        tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h00, 32'h0,        1'b0, 32'hFFFFF080, 2};
        tbl[9]  = '{1'b0, 2'd1, 1'b0, 32'h03, 32'h0,        1'b1, 32'h0,        1};
        tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h02, 32'h12345678, 1'b1, 32'h0,        1};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h54, 32'h0,        1'b1, 32'h0,        1};
        tbl[12] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        1'b1, 32'h0,        1};
        tbl[13] = '{1'b1, 2'd2, 1'b0, 32'h50, 32'h5A5A0001, 1'b0, 32'h0,        2};
        tbl[14] = '{1'b0, 2'd1, 1'b1, 32'h52, 32'h0,        1'b0, 32'h00005A5A, 2};
        tbl[15] = '{1'b1, 2'd1, 1'b0, 32'h52, 32'h12348001, 1'b0, 32'h0,        3};
        tbl[16] = '{1'b0, 2'd1, 1'b1, 32'h52, 32'h0,        1'b0, 32'hFFFF8001, 2};

        for (int i = 0; i < int'(MW); i++) ref_mem[i] = 32'b0;
        rst_n = 1'b0; mem_clear = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'b0; req_wdata = 32'b0;

        // Reset values
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_read_address", read_address, 32'd0);
        chk("rst_write_address", write_address, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; mem_clear = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 17; i++) begin
            model(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, e, rd, lat);
            do_req($sformatf("tbl%0d", i), tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a,
                   tbl[i].wd, tbl[i].err, tbl[i].rd, tbl[i].lat);
        end

        // Back-to-back loads with req_valid held high
        exp_r = 5'b00100;
        exp_v = 5'b10010;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h08; req_wdata = 32'h0;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        chk("b2b_first_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_addr = 32'h04;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("b2b_ready_c%0d", c), 32'(req_ready), 32'(exp_r[c-1]));
            chk($sformatf("b2b_valid_c%0d", c), 32'(resp_valid), 32'(exp_v[c-1]));
            if (c == 2) chk("b2b_rdata_first", resp_rdata, ref_mem[2]);
            if (c == 5) chk("b2b_rdata_second", resp_rdata, ref_mem[1]);
            if (c < 5) begin @(posedge clk); #1; end
        end
        req_valid = 1'b0;
        @(posedge clk); #1;

        // Reset asserted while a byte store sits in RD
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h05; req_wdata = 32'h00000055;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        mw0 = mw_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready_after_release", 32'(req_ready), 32'd1);
        chk("abort_no_resp", 32'(resp_valid), 32'd0);
        chk("abort_mem_writes", 32'(mw_count - mw0), 32'd0);
        chk("abort_mem_unchanged", mem[1], ref_mem[1]);

        // Randomized requests against the reference model
        for (int i = 0; i < 200; i++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 22) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = $urandom;
            wd = $urandom;
            model(w, sz, sg, a, wd, e, rd, lat);
            do_req($sformatf("rnd%0d", i), w, sz, sg, a, wd, e, rd, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
